uart_tx_queue: RTL and testbench

- Byte FIFO plus drain FSM between the MMIO to_host write path and UARTTX.
- A store to 0xF0000100 pushes a byte. The processor polls FULL instead of UARTTX READY, so bursts of up to 2**DEPTH_LOG bytes never stall.
- The drain side feeds UARTTX through its DATA/WE/READY handshake, one byte per UART frame.

---
 rtl/uart_tx_queue_pkg.sv | 12 +
 rtl/uart_tx_queue_sync_fifo.sv | 71 +++++++
 rtl/uart_tx_queue.sv | 74 +++++++
 tb/tb_uart_tx_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: drain FSM encoding and MMIO address.
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_WAIT  = 2'd2
    } tx_state_e;

    localparam logic [15:0] TO_HOST_ADDR = 16'h0100;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags; pushes are dropped when full.
module uart_tx_queue_sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_async_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int              DEPTH     = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wptr;
    logic [DEPTH_LOG-1:0] rptr;
    logic                 do_push;
    logic                 do_pop;
    logic [DEPTH_LOG:0]   count_nxt;

    // Flags are registered, so push acceptance uses last cycle's FULL even when a pop frees a slot.
    always_comb begin
        do_push   = push && !flush && !full;
        do_pop    = pop && !flush && !empty;
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_nxt = count + (DEPTH_LOG + 1)'(1);
                2'b01:   count_nxt = count - (DEPTH_LOG + 1)'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + DEPTH_LOG'(1);
                if (do_pop)  rptr <= rptr + DEPTH_LOG'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue between the to_host MMIO store path and UARTTX, draining one byte per frame.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 FLUSH,
    input  logic [7:0]           WDATA,
    input  logic                 WE,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic                 OVERFLOW,
    output logic [7:0]           TX_DATA,
    output logic                 TX_WE,
    input  logic                 TX_READY
);

    tx_state_e  state;
    tx_state_e  state_nxt;
    logic       pop;
    logic [7:0] fifo_rdata;

    uart_tx_queue_sync_fifo #(
        .WIDTH     (8),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk         (CLK),
        .rst_async_n (RST_X),
        .flush       (FLUSH),
        .push        (WE),
        .pop         (pop),
        .wdata       (WDATA),
        .rdata       (fifo_rdata),
        .full        (FULL),
        .empty       (EMPTY),
        .count       (COUNT)
    );

    // GUARD skips one cycle of TX_READY because UARTTX drops READY a cycle after WE.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!EMPTY && TX_READY && !FLUSH) begin
                    pop       = 1'b1;
                    state_nxt = S_GUARD;
                end
            end
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT:  if (TX_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state    <= S_IDLE;
            TX_WE    <= 1'b0;
            TX_DATA  <= 8'h00;
            OVERFLOW <= 1'b0;
        end else begin
            state <= state_nxt;
            TX_WE <= pop;
            if (pop) TX_DATA <= fifo_rdata;
            if (FLUSH)           OVERFLOW <= 1'b0;
            else if (WE && FULL) OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a behavioural UARTTX and a queue-based reference model.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;

    logic       CLK;
    logic       RST_X;
    logic       FLUSH;
    logic [7:0] WDATA;
    logic       WE;
    logic       FULL;
    logic       EMPTY;
    logic [4:0] COUNT;
    logic       OVERFLOW;
    logic [7:0] TX_DATA;
    logic       TX_WE;
    logic       TX_READY;

    uart_tx_queue #(.DEPTH_LOG(4)) dut (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .FLUSH    (FLUSH),
        .WDATA    (WDATA),
        .WE       (WE),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW),
        .TX_DATA  (TX_DATA),
        .TX_WE    (TX_WE),
        .TX_READY (TX_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic       prev_we = 1'b0;
    int         cyc = 0;
    int         lat_edge = 0;
    bit         lat_armed = 1'b0;

    // UARTTX model: READY falls on the edge after WE and stays low for a random frame time.
    logic       ready_en;
    int         busy;
    assign TX_READY = ready_en && (busy == 0);

    always @(posedge CLK or negedge RST_X) begin
        if (!RST_X)     busy <= 0;
        else if (TX_WE) busy <= int'($urandom_range(2, 6));
        else if (busy > 0) busy <= busy - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Monitor: pops the expected byte on every TX_WE and checks the flags against the model.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (RST_X) begin
            if (TX_WE) begin
                chk("tx_we_one_cycle", 32'(prev_we), 32'd0);
                chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("tx_data", 32'(TX_DATA), 32'(exp_q.pop_front()));
                if (lat_armed) begin
                    chk("tx_latency", 32'(cyc), 32'(lat_edge + 1));
                    lat_armed = 1'b0;
                end
                last_data = TX_DATA;
            end else begin
                chk("tx_data_hold", 32'(TX_DATA), 32'(last_data));
            end
            chk("count", 32'(COUNT), 32'(exp_q.size()));
            chk("full", 32'(FULL), 32'(exp_q.size() == DEPTH));
            chk("empty", 32'(EMPTY), 32'(exp_q.size() == 0));
            chk("overflow", 32'(OVERFLOW), 32'(exp_ovf));
            prev_we = TX_WE;
        end
    end

    // Drive one cycle of stimulus before the next edge and apply its effect to the model.
    task automatic drive(input logic we, input logic [7:0] d, input logic fl, input logic rdy);
        @(negedge CLK);
        WE = we;
        WDATA = d;
        FLUSH = fl;
        ready_en = rdy;
        if (fl) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else if (we) begin
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(d);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        RST_X = 1'b0;
        WE = 1'b0;
        WDATA = 8'h00;
        FLUSH = 1'b0;
        ready_en = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_tx_we", 32'(TX_WE), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        RST_X = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Single byte with latency measurement.
        drive(1'b1, 8'h41, 1'b0, 1'b1);
        lat_edge = cyc + 1;
        lat_armed = 1'b1;
        wait_drain();
        chk("latency_seen", 32'(lat_armed), 32'd0);

        // Fill while READY is held low, overflow, then READY rises with a push on the same edge.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'hBB, 1'b0, 1'b1);
        wait_drain();

        // Flush while a byte is in flight, with OVERFLOW set and seven bytes queued.
        for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2000 && exp_q.size() > 7; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_setup", 32'(exp_q.size()), 32'd7);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'hCC, 1'b1, 1'b1);
        repeat (30) drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic with READY gating and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ready_en = ~ready_en;
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 63) == 0), ready_en);
        end
        wait_drain();

        // Wrap: stream 40 random bytes through the 16-entry queue without dropping any.
        n = 0;
        for (int i = 0; i < 3000 && n < 40; i++) begin
            if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                drive(1'b1, 8'($urandom), 1'b0, 1'b1);
                n++;
            end else begin
                drive(1'b0, 8'h00, 1'b0, 1'b1);
            end
        end
        chk("wrap_pushed", 32'(n), 32'd40);
        wait_drain();

        // Asynchronous reset while the drain FSM is in GUARD.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        WE = 1'b0;
        for (int i = 0; i < 50 && !TX_WE; i++) @(negedge CLK);
        chk("guard_reached", 32'(TX_WE), 32'd1);
        #2;
        RST_X = 1'b0;
        #1;
        chk("arst_count", 32'(COUNT), 32'd0);
        chk("arst_empty", 32'(EMPTY), 32'd1);
        chk("arst_full", 32'(FULL), 32'd0);
        chk("arst_overflow", 32'(OVERFLOW), 32'd0);
        chk("arst_tx_we", 32'(TX_WE), 32'd0);
        chk("arst_tx_data", 32'(TX_DATA), 32'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        prev_we = 1'b0;
        last_data = 8'h00;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
